ddr3_wdata_burst: RTL and testbench

DDR3_WDATA_BURST -- requirements
Module: ddr3_wdata_burst

---
 rtl/ddr3_wdata_burst.sv | 140 ++++++++++++++
 tb/tb_ddr3_wdata_burst.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_wdata_burst.sv
`timescale 1ns/1ps
// DDR3 write-data burst sequencer for one 8-bit lane.
// Accepts a BL8 burst, waits CWL cycles, then drives four d0/d1 beat pairs
// with aligned data mask, DQ output enable and DQS output enable with a
// one-cycle preamble. All beat outputs are registered.
//
// state | meaning
// IDLE  | ready for a burst; wr_ready high
// WAIT  | burst held, counting down write latency
// BURST | driving beat pairs k=0..3
module ddr3_wdata_burst #(
  parameter int CWL = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_valid,
  input  logic [63:0] wr_data,
  input  logic [7:0]  wr_mask,
  output logic        wr_ready,
  output logic [7:0]  d0,
  output logic [7:0]  d1,
  output logic        dm0,
  output logic        dm1,
  output logic        dq_oe,
  output logic        dqs_oe,
  output logic [15:0] burst_cnt
);

  localparam logic [3:0] CWL_M1 = 4'(CWL - 1);

  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

  state_t      state_q, state_d;
  logic [3:0]  lat_q, lat_d;
  logic [1:0]  beat_q, beat_d;
  logic [63:0] hold_data_q, hold_data_d;
  logic [7:0]  hold_mask_q, hold_mask_d;
  logic [7:0]  d0_q, d0_d, d1_q, d1_d;
  logic        dm0_q, dm0_d, dm1_q, dm1_d;
  logic        dq_oe_q, dq_oe_d, dqs_oe_q, dqs_oe_d;
  logic [15:0] burst_cnt_q, burst_cnt_d;

  logic        out_load;
  logic [1:0]  nxt_beat;
  logic [5:0]  base;

  // Next-state, latency/beat counters and registered beat outputs.
  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    beat_d      = beat_q;
    hold_data_d = hold_data_q;
    hold_mask_d = hold_mask_q;
    burst_cnt_d = burst_cnt_q;
    dqs_oe_d    = dqs_oe_q;
    out_load    = 1'b0;
    nxt_beat    = beat_q;
    case (state_q)
      IDLE: begin
        if (wr_valid) begin
          state_d     = WAIT;
          lat_d       = CWL_M1;
          hold_data_d = wr_data;
          hold_mask_d = wr_mask;
        end
      end
      WAIT: begin
        if (lat_q == 4'd0) begin
          state_d  = BURST;
          beat_d   = 2'd0;
          nxt_beat = 2'd0;
          out_load = 1'b1;
        end else begin
          lat_d = lat_q - 4'd1;
          // preamble: DQS enable goes up one cycle ahead of the first beat
          if (lat_q == 4'd1) dqs_oe_d = 1'b1;
        end
      end
      BURST: begin
        if (beat_q == 2'd3) begin
          state_d     = IDLE;
          dqs_oe_d    = 1'b0;
          burst_cnt_d = burst_cnt_q + 16'd1;
        end else begin
          beat_d   = beat_q + 2'd1;
          nxt_beat = beat_q + 2'd1;
          out_load = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    base    = {nxt_beat, 4'b0000};
    d0_d    = out_load ? hold_data_q[base +: 8] : 8'h00;
    d1_d    = out_load ? hold_data_q[base + 6'd8 +: 8] : 8'h00;
    dm0_d   = out_load & hold_mask_q[{nxt_beat, 1'b0}];
    dm1_d   = out_load & hold_mask_q[{nxt_beat, 1'b1}];
    dq_oe_d = out_load;
  end

  // State and output registers; reset drops any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lat_q       <= 4'd0;
      beat_q      <= 2'd0;
      hold_data_q <= 64'd0;
      hold_mask_q <= 8'd0;
      d0_q        <= 8'h00;
      d1_q        <= 8'h00;
      dm0_q       <= 1'b0;
      dm1_q       <= 1'b0;
      dq_oe_q     <= 1'b0;
      dqs_oe_q    <= 1'b0;
      burst_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      beat_q      <= beat_d;
      hold_data_q <= hold_data_d;
      hold_mask_q <= hold_mask_d;
      d0_q        <= d0_d;
      d1_q        <= d1_d;
      dm0_q       <= dm0_d;
      dm1_q       <= dm1_d;
      dq_oe_q     <= dq_oe_d;
      dqs_oe_q    <= dqs_oe_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign wr_ready  = (state_q == IDLE);
  assign d0        = d0_q;
  assign d1        = d1_q;
  assign dm0       = dm0_q;
  assign dm1       = dm1_q;
  assign dq_oe     = dq_oe_q;
  assign dqs_oe    = dqs_oe_q;
  assign burst_cnt = burst_cnt_q;

endmodule

// File: tb/tb_ddr3_wdata_burst.sv
`timescale 1ns/1ps
// Bench for ddr3_wdata_burst: a CWL=5 instance and a CWL=2 instance.
module tb_ddr3_wdata_burst;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        wv1, wv2;
  logic [63:0] wd1, wd2;
  logic [7:0]  wm1, wm2;
  logic        rdy1, rdy2, dm0_1, dm1_1, dm0_2, dm1_2;
  logic        dq1, dq2, dqs1, dqs2;
  logic [7:0]  d0_1, d1_1, d0_2, d1_2;
  logic [15:0] cnt1, cnt2;

  ddr3_wdata_burst #(.CWL(5)) dut1 (
    .clk(clk), .rst_n(rst_n), .wr_valid(wv1), .wr_data(wd1), .wr_mask(wm1),
    .wr_ready(rdy1), .d0(d0_1), .d1(d1_1), .dm0(dm0_1), .dm1(dm1_1),
    .dq_oe(dq1), .dqs_oe(dqs1), .burst_cnt(cnt1));

  ddr3_wdata_burst #(.CWL(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .wr_valid(wv2), .wr_data(wd2), .wr_mask(wm2),
    .wr_ready(rdy2), .d0(d0_2), .d1(d1_2), .dm0(dm0_2), .dm1(dm1_2),
    .dq_oe(dq2), .dqs_oe(dqs2), .burst_cnt(cnt2));

  typedef struct packed {
    logic        rdy;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic        dm0;
    logic        dm1;
    logic        dq;
    logic        dqs;
    logic [15:0] cnt;
  } obs_t;

  // beat pair k of expected d0/d1 sits at [8k+:8], dm at bit k
  typedef struct {
    logic [63:0] data;
    logic [7:0]  mask;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [3:0]  em0;
    logic [3:0]  em1;
  } vec_t;

  vec_t vecs[3];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [15:0] exp_cnt1 = 16'd0;
  logic [15:0] exp_cnt2 = 16'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic obs_t samp(input int sel);
    obs_t o;
    if (sel == 0) o = '{rdy1, d0_1, d1_1, dm0_1, dm1_1, dq1, dqs1, cnt1};
    else          o = '{rdy2, d0_2, d1_2, dm0_2, dm1_2, dq2, dqs2, cnt2};
    return o;
  endfunction

  task automatic drive(input int sel, input logic v, input logic [63:0] d, input logic [7:0] m);
    if (sel == 0) begin wv1 = v; wd1 = d; wm1 = m; end
    else          begin wv2 = v; wd2 = d; wm2 = m; end
  endtask

  // Called at a negedge with the instance idle. After acceptance, wr_valid
  // stays high with inverted data so late changes and valid-while-busy are
  // exercised together. Returns at a negedge with valid low.
  task automatic run_burst(input int sel, input int cwl, input vec_t v,
                           input logic [15:0] prev, input string tag);
    obs_t o;
    int   k;
    logic in_b;
    drive(sel, 1'b1, v.data, v.mask);
    chk({tag, "_ready_pre"}, 32'(samp(sel).rdy), 32'd1);
    @(posedge clk); #1;
    drive(sel, 1'b1, ~v.data, ~v.mask);
    for (int j = 0; j <= cwl + 4; j++) begin
      if (j > 0) begin @(posedge clk); #1; end
      o    = samp(sel);
      in_b = (j >= cwl) && (j <= cwl + 3);
      k    = j - cwl;
      chk($sformatf("%s_rdy_T%0d", tag, j), 32'(o.rdy), 32'(j == cwl + 4));
      chk($sformatf("%s_dqs_T%0d", tag, j), 32'(o.dqs), 32'((j >= cwl - 1) && (j <= cwl + 3)));
      chk($sformatf("%s_dq_T%0d", tag, j),  32'(o.dq),  32'(in_b));
      chk($sformatf("%s_d0_T%0d", tag, j),  32'(o.d0),  in_b ? 32'(v.e0[8*k +: 8]) : 32'd0);
      chk($sformatf("%s_d1_T%0d", tag, j),  32'(o.d1),  in_b ? 32'(v.e1[8*k +: 8]) : 32'd0);
      chk($sformatf("%s_dm0_T%0d", tag, j), 32'(o.dm0), in_b ? 32'(v.em0[k]) : 32'd0);
      chk($sformatf("%s_dm1_T%0d", tag, j), 32'(o.dm1), in_b ? 32'(v.em1[k]) : 32'd0);
      chk($sformatf("%s_cnt_T%0d", tag, j), 32'(o.cnt),
          (j == cwl + 4) ? 32'(16'(prev + 16'd1)) : 32'(prev));
    end
    @(negedge clk);
    drive(sel, 1'b0, 64'd0, 8'd0);
  endtask

  initial begin
    obs_t o;
    int   ph;
    vecs[0] = '{64'h7766554433221100, 8'h00, 32'h66442200, 32'h77553311, 4'b0000, 4'b0000};
    vecs[1] = '{64'h0123456789ABCDEF, 8'hA5, 32'h2367ABEF, 32'h014589CD, 4'b0011, 4'b1100};
    vecs[2] = '{64'hFFEEDDCCBBAA9988, 8'hFF, 32'hEECCAA88, 32'hFFDDBB99, 4'b1111, 4'b1111};

    rst_n = 1'b0;
    drive(0, 1'b0, 64'd0, 8'd0);
    drive(1, 1'b0, 64'd0, 8'd0);
    #2;
    o = samp(0);
    chk("rst_rdy", 32'(o.rdy), 32'd1);
    chk("rst_d0",  32'(o.d0),  32'd0);
    chk("rst_d1",  32'(o.d1),  32'd0);
    chk("rst_dm",  32'({o.dm0, o.dm1}), 32'd0);
    chk("rst_oe",  32'({o.dq, o.dqs}), 32'd0);
    chk("rst_cnt", 32'(o.cnt), 32'd0);

    // release with valid high: accepted on the first rising edge, then
    // reset is pulsed during beat 1
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1'b1, vecs[0].data, vecs[0].mask);
    @(posedge clk); #1;
    drive(0, 1'b0, 64'd0, 8'd0);
    chk("first_edge_accept", 32'(rdy1), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_beat1_d0", 32'(d0_1), 32'h22);
    chk("midrst_beat1_d1", 32'(d1_1), 32'h33);
    chk("midrst_dq",       32'(dq1),  32'd1);
    #2 rst_n = 1'b0;
    #1;
    o = samp(0);
    chk("midrst_d",   32'({o.d0, o.d1}), 32'd0);
    chk("midrst_dm",  32'({o.dm0, o.dm1}), 32'd0);
    chk("midrst_oe",  32'({o.dq, o.dqs}), 32'd0);
    chk("midrst_rdy", 32'(o.rdy), 32'd1);
    chk("midrst_cnt", 32'(o.cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("after_rst_quiet", 32'({d0_1, d1_1, dq1, dqs1, cnt1}), 32'd0);

    // table-driven bursts on CWL=5
    for (int i = 0; i < 3; i++) begin
      run_burst(0, 5, vecs[i], exp_cnt1, $sformatf("v%0d", i));
      exp_cnt1 = exp_cnt1 + 16'd1;
    end

    // wr_valid held high: accepts at T, T+10, T+20
    drive(0, 1'b1, vecs[1].data, vecs[1].mask);
    @(posedge clk); #1;
    for (int j = 0; j <= 20; j++) begin
      if (j > 0) begin @(posedge clk); #1; end
      o  = samp(0);
      ph = j % 10;
      chk($sformatf("cont_rdy_T%0d", j), 32'(o.rdy), 32'(ph == 9));
      chk($sformatf("cont_dq_T%0d", j),  32'(o.dq),  32'((ph >= 5) && (ph <= 8)));
      chk($sformatf("cont_d0_T%0d", j),  32'(o.d0),
          ((ph >= 5) && (ph <= 8)) ? 32'(vecs[1].e0[8*(ph-5) +: 8]) : 32'd0);
      chk($sformatf("cont_cnt_T%0d", j), 32'(o.cnt),
          32'(16'(exp_cnt1 + 16'(j >= 9) + 16'(j >= 19))));
    end
    @(negedge clk);
    drive(0, 1'b0, 64'd0, 8'd0);
    for (int i = 0; i < 20 && !rdy1; i++) @(negedge clk);
    chk("cont_drain_rdy", 32'(rdy1), 32'd1);
    exp_cnt1 = exp_cnt1 + 16'd3;
    chk("cont_drain_cnt", 32'(cnt1), 32'(exp_cnt1));

    // CWL=2 instance: preamble at T+1, first beat at T+2
    run_burst(1, 2, vecs[0], exp_cnt2, "cwl2");
    exp_cnt2 = exp_cnt2 + 16'd1;

    // counter wrap: stand in for 65535 completed bursts
    force dut1.burst_cnt_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut1.burst_cnt_q;
    chk("wrap_preset", 32'(cnt1), 32'hFFFF);
    @(negedge clk);
    run_burst(0, 5, vecs[2], 16'hFFFF, "wrap");
    chk("wrap_zero", 32'(cnt1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
